// File: rtl/berzerk_pkg.sv
// Shared types and defaults for the Berzerk program-ROM download/CPU arbiter.
package berzerk_pkg;

  localparam int AW_DEFAULT = 16;
  localparam logic [15:0] ROM_TOP_DEFAULT = 16'hBFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_DATA = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dl_rom_arbiter.sv
// Shares one single-port program memory between the HPS byte download and CPU reads.
// Download bytes park in a one-entry holding register and are written when the port is free.
module dl_rom_arbiter
  import berzerk_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter logic [AW-1:0] ROM_TOP = AW'(ROM_TOP_DEFAULT)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dn_download,
  input  logic [AW-1:0] dn_addr,
  input  logic [7:0]    dn_data,
  input  logic          dn_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_data,
  output logic          cpu_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [AW:0]   dl_bytes,
  output logic          dl_done,
  output logic          dl_overflow,
  output arb_state_e    state_dbg
);

  localparam logic [AW:0] BYTES_MAX = {1'b1, {AW{1'b0}}};

  arb_state_e    state;
  logic          hold_valid;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_data;
  logic          dn_download_q;
  logic          dl_pending;

  logic          draining;
  logic          wr_in_range;
  logic          hold_load;
  logic          wr_drop;
  logic          dl_rise;
  logic          dl_fall;
  logic [AW:0]   bytes_base;
  logic [AW:0]   bytes_next;

  // A write slot drains the holding register; a byte arriving in that same
  // cycle refills it instead of being dropped.
  assign draining    = (state == ST_WR);
  assign wr_in_range = dn_wr && (dn_addr <= ROM_TOP);
  assign hold_load   = wr_in_range && (!hold_valid || draining);
  assign wr_drop     = wr_in_range && hold_valid && !draining;
  assign dl_rise     = dn_download && !dn_download_q;
  assign dl_fall     = !dn_download && dn_download_q;

  assign mem_we    = draining && !reset;
  assign mem_addr  = draining ? hold_addr : cpu_addr;
  assign mem_wdata = hold_data;
  assign state_dbg = state;

  // Done waits for the last parked byte to reach memory.
  assign dl_done = !reset && !dn_download && (dl_pending || dn_download_q) && !hold_valid;

  always_comb begin
    bytes_base = dl_rise ? '0 : dl_bytes;
    bytes_next = bytes_base;
    if (hold_load && (bytes_base != BYTES_MAX)) begin
      bytes_next = bytes_base + (AW+1)'(1);
    end
  end

  // CPU handshake: cpu_rd is a level held (with cpu_addr stable) until the
  // one-cycle cpu_ack, which carries cpu_data; the ack cycle never starts a read.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= ST_IDLE;
      hold_valid    <= 1'b0;
      hold_addr     <= '0;
      hold_data     <= '0;
      cpu_data      <= '0;
      cpu_ack       <= 1'b0;
      dl_bytes      <= '0;
      dl_overflow   <= 1'b0;
      dn_download_q <= 1'b0;
      dl_pending    <= 1'b0;
    end else begin
      dn_download_q <= dn_download;
      dl_pending    <= (dl_pending || dl_fall) && !dl_done;
      dl_bytes      <= bytes_next;
      dl_overflow   <= (dl_overflow && !dl_rise) || wr_drop;
      cpu_ack       <= 1'b0;

      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_addr  <= dn_addr;
        hold_data  <= dn_data;
      end else if (draining) begin
        hold_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            state <= ST_WR;
          end else if (cpu_rd && !dn_download && !cpu_ack) begin
            state <= ST_RD_ADDR;
          end
        end
        ST_WR:      state <= ST_IDLE;
        ST_RD_ADDR: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          cpu_data <= mem_rdata;
          cpu_ack  <= 1'b1;
          state    <= ST_IDLE;
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_rom_arbiter.sv
// Bench for dl_rom_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-scheduling reference model.
module tb_dl_rom_arbiter;
  import berzerk_pkg::*;

  localparam int AW = 16;
  localparam logic [AW-1:0] ROM_TOP = 16'hBFFF;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic          dn_download = 1'b0;
  logic [AW-1:0] dn_addr     = '0;
  logic [7:0]    dn_data     = '0;
  logic          dn_wr       = 1'b0;
  logic [AW-1:0] cpu_addr    = '0;
  logic          cpu_rd      = 1'b0;
  logic [7:0]    cpu_data;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [AW:0]   dl_bytes;
  logic          dl_done;
  logic          dl_overflow;
  arb_state_e    state_dbg;

  dl_rom_arbiter #(.AW(AW), .ROM_TOP(ROM_TOP)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dn_download(dn_download), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dl_bytes(dl_bytes), .dl_done(dl_done), .dl_overflow(dl_overflow),
    .state_dbg(state_dbg)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ---------------- program memory (environment) ----------------
  logic [7:0] mem [0:65535];
  logic       mem_ready = 1'b0;
  int         we_count  = 0;
  always @(posedge clk_sys) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The memory port is a resource: each free cycle either schedules the
  // parked byte for the next cycle, or a read whose ack lands 3 cycles on.
  int          cyc = 0;
  int          next_free, wr_cyc, rd_addr_cyc, ack_cyc;
  logic [23:0] exp_q [$];
  logic [7:0]  ref_wr [int];
  int          m_bytes;
  logic        m_ovf, m_prev_dl, m_done_owed;
  logic [7:0]  m_cpu_data, m_rd_data;

  function automatic logic [7:0] expected_byte(input logic [15:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_byte(a);
  endfunction

  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (reset) begin
        exp_q.delete();
        next_free   = cyc + 1;
        wr_cyc      = -1;
        rd_addr_cyc = -1;
        ack_cyc     = -1;
        m_bytes     = 0;
        m_ovf       = 1'b0;
        m_prev_dl   = 1'b0;
        m_done_owed = 1'b0;
        m_cpu_data  = 8'h00;
        m_rd_data   = 8'h00;
      end else begin
        logic exp_we, exp_done, hold_busy, rise, fall;
        hold_busy = (exp_q.size() != 0);
        exp_we    = (cyc == wr_cyc);
        exp_done  = !dn_download && (m_done_owed || m_prev_dl) && !hold_busy;
        if (cyc == rd_addr_cyc) m_rd_data = expected_byte(cpu_addr);
        if (cyc == ack_cyc) m_cpu_data = m_rd_data;

        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), exp_we ? 32'(exp_q[0][23:8]) : 32'(cpu_addr));
        if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(exp_q[0][7:0]));
        check("cpu_ack", 32'(cpu_ack), 32'(cyc == ack_cyc));
        check("cpu_data", 32'(cpu_data), 32'(m_cpu_data));
        check("dl_bytes", 32'(dl_bytes), 32'(m_bytes));
        check("dl_overflow", 32'(dl_overflow), 32'(m_ovf));
        check("dl_done", 32'(dl_done), 32'(exp_done));
        check("ack_in_download", 32'(cpu_ack && dn_download), 32'd0);

        if (exp_we) begin
          ref_wr[int'(exp_q[0][23:8])] = exp_q[0][7:0];
          exp_q.delete();
        end
        rise = dn_download && !m_prev_dl;
        fall = !dn_download && m_prev_dl;
        if (rise) begin
          m_bytes = 0;
          m_ovf   = 1'b0;
        end
        if (dn_wr && (dn_addr <= ROM_TOP)) begin
          if (!hold_busy || exp_we) begin
            exp_q.delete();
            exp_q.push_back({dn_addr, dn_data});
            if (m_bytes < 65536) m_bytes = m_bytes + 1;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (cyc >= next_free) begin
          if (hold_busy) begin
            wr_cyc    = cyc + 1;
            next_free = cyc + 2;
          end else if (cpu_rd && !dn_download && (cyc != ack_cyc)) begin
            rd_addr_cyc = cyc + 1;
            ack_cyc     = cyc + 3;
            next_free   = cyc + 3;
          end
        end
        m_done_owed = (m_done_owed || fall) && !exp_done;
        m_prev_dl   = dn_download;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic sample();
    @(negedge clk_sys);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_cpu_data"}, 32'(cpu_data), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_dl_bytes"}, 32'(dl_bytes), 32'd0);
    check({tag, "_dl_done"}, 32'(dl_done), 32'd0);
    check({tag, "_dl_overflow"}, 32'(dl_overflow), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  function automatic logic [15:0] pick_dn_addr();
    case ($urandom_range(0, 3))
      0:       return ROM_TOP;
      1:       return ROM_TOP + 16'd1;
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int we0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    sample();
    check_reset_values("reset");

    // CPU read of a preloaded location: ack exactly 3 cycles after request.
    step();
    cpu_addr = 16'h1234;
    cpu_rd   = 1'b1;
    sample();
    check("rd_lat_c0", 32'(cpu_ack), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      sample();
      check($sformatf("rd_lat_c%0d", k), 32'(cpu_ack), 32'(k == 3));
    end
    check("rd_data_1234", 32'(cpu_data), 32'h5A);
    step();
    cpu_rd = 1'b0;

    // Full 256-byte download, one byte every 4 cycles.
    we0 = we_count;
    dn_download = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dn_wr   = 1'b1;
      dn_addr = 16'(i);
      dn_data = 8'(i);
      step();
      dn_wr = 1'b0;
      repeat (3) step();
    end
    sample();
    check("dl256_we_pulses", 32'(we_count - we0), 32'd256);
    check("dl256_bytes", 32'(dl_bytes), 32'd256);
    check("dl256_overflow", 32'(dl_overflow), 32'd0);
    check("dl256_mem_00", 32'(mem[16'h0000]), 32'h00);
    check("dl256_mem_7f", 32'(mem[16'h007F]), 32'h7F);
    check("dl256_mem_ff", 32'(mem[16'h00FF]), 32'hFF);

    // Write just above ROM_TOP is ignored.
    we0 = we_count;
    step();
    dn_wr   = 1'b1;
    dn_addr = 16'hC000;
    dn_data = 8'hEE;
    step();
    dn_wr = 1'b0;
    repeat (4) step();
    sample();
    check("c000_no_write", 32'(we_count - we0), 32'd0);
    check("c000_bytes", 32'(dl_bytes), 32'd256);
    step();
    dn_download = 1'b0;
    repeat (3) step();

    // Two back-to-back writes while a read is in its address cycle.
    cpu_addr = 16'h2345;
    cpu_rd   = 1'b1;
    step();
    dn_wr   = 1'b1;
    dn_addr = 16'h0100;
    dn_data = 8'hA1;
    step();
    dn_addr = 16'h0101;
    dn_data = ~init_byte(16'h0101);
    step();
    dn_wr = 1'b0;
    sample();
    check("ovf_read_ack", 32'(cpu_ack), 32'd1);
    check("ovf_read_data", 32'(cpu_data), 32'(init_byte(16'h2345)));
    step();
    cpu_rd = 1'b0;
    repeat (4) step();
    sample();
    check("ovf_flag", 32'(dl_overflow), 32'd1);
    check("ovf_first_written", 32'(mem[16'h0100]), 32'hA1);
    check("ovf_second_dropped", 32'(mem[16'h0101]), 32'(init_byte(16'h0101)));
    check("ovf_bytes", 32'(dl_bytes), 32'd257);

    // Download ends with a byte still parked: done one cycle after the drain.
    step();
    dn_download = 1'b1;
    step();
    dn_wr   = 1'b1;
    dn_addr = 16'h0200;
    dn_data = 8'h33;
    step();
    dn_wr       = 1'b0;
    dn_download = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("done_c%0d", k), 32'(dl_done), 32'(k == 2));
      step();
    end
    check("done_byte_written", 32'(mem[16'h0200]), 32'h33);

    // Reset during the read data cycle: no ack, everything back to reset values.
    cpu_addr = 16'h3000;
    cpu_rd   = 1'b1;
    step();
    step();
    reset  = 1'b1;
    cpu_rd = 1'b0;
    step();
    reset = 1'b0;
    sample();
    check_reset_values("rst_rd");

    // Reset during the write slot: the parked byte never reaches memory.
    step();
    dn_wr   = 1'b1;
    dn_addr = 16'h0300;
    dn_data = ~init_byte(16'h0300);
    step();
    dn_wr = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    sample();
    check("rst_wr_discard", 32'(mem[16'h0300]), 32'(init_byte(16'h0300)));
    check("rst_wr_bytes", 32'(dl_bytes), 32'd0);

    // Randomized traffic: CPU phases with sparse stray writes, download phases.
    for (int blk = 0; blk < 30; blk++) begin
      if (blk % 3 == 2) begin
        dn_download = 1'b1;
        for (int k = 0; k < 40; k++) begin
          step();
          dn_wr   = ($urandom_range(0, 1) == 1);
          dn_addr = pick_dn_addr();
          dn_data = 8'($urandom);
        end
        step();
        dn_wr       = 1'b0;
        dn_download = 1'b0;
        repeat (3) step();
      end else begin
        for (int k = 0; k < 60; k++) begin
          step();
          if (cpu_ack) begin
            cpu_rd = 1'b0;
          end else if (!cpu_rd && ($urandom_range(0, 2) == 0)) begin
            cpu_addr = 16'($urandom_range(0, 16'hFFFF));
            cpu_rd   = 1'b1;
          end
          dn_wr   = ($urandom_range(0, 5) == 0);
          dn_addr = pick_dn_addr();
          dn_data = 8'($urandom);
        end
        step();
        dn_wr = 1'b0;
        for (int k = 0; k < 20 && cpu_rd; k++) begin
          if (cpu_ack) cpu_rd = 1'b0;
          else step();
        end
        sample();
        check("rd_drain_timeout", 32'(cpu_rd), 32'd0);
        cpu_rd = 1'b0;
        step();
      end
    end
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
